// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the multi-channel telemetry framer.
// Frame layout: SYNC, SEQ, MASK, NUM_CH x {MSB, LSB}, CHK.
package telemetry_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  function automatic int frame_len(input int num_ch);
    return 4 + 2 * num_ch;
  endfunction

endpackage

// File: rtl/framer_capture_bank.sv
// Per-channel hold/fresh registers, drop counter and frame snapshot (shadow + mask).
// Capture is single-cycle; a snapshot takes the registered hold/fresh values, never the same-cycle input.
module framer_capture_bank #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DW-1:0]     value_i,
  input  logic [NUM_CH-1:0]        valid_i,
  input  logic                     snap,
  output logic [NUM_CH-1:0]        fresh,
  output logic [NUM_CH-1:0][15:0]  shadow,
  output logic [7:0]               mask,
  output logic [7:0]               drop_cnt
);

  logic [NUM_CH-1:0][15:0] hold;
  logic [3:0]              drops;
  logic [8:0]              drop_sum;
  logic [7:0]              drop_next;

  // A drop is a fresh value overwritten without a snapshot taking it first.
  always_comb begin
    drops = 4'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fresh[c] && valid_i[c] && !snap) drops = drops + 4'd1;
    end
    drop_sum  = {1'b0, drop_cnt} + {5'b0, drops};
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      fresh    <= '0;
      shadow   <= '0;
      mask     <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (valid_i[c]) hold[c] <= 16'(value_i[c*DW +: DW]);
      end
      // Same-cycle valid survives the snapshot clear and rides in the next frame.
      fresh    <= (snap ? '0 : fresh) | valid_i;
      drop_cnt <= drop_next;
      if (snap) begin
        shadow <= hold;
        mask   <= 8'(fresh);
      end
    end
  end

endmodule

// File: rtl/telemetry_framer.sv
// Packs NUM_CH latest results into checksummed UART frames; trigger at t, SYNC written t+1.
// Backpressure: byte_full_i stalls the byte index and write strobe in the same cycle.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          DW             = 16,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC,
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] value_i,
  input  logic [NUM_CH-1:0]    valid_i,
  output logic [7:0]           byte_o,
  output logic                 byte_wr_o,
  input  logic                 byte_full_i,
  output logic                 busy_o,
  output logic [7:0]           seq_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int         LEN  = frame_len(NUM_CH);
  localparam logic [4:0] LAST = 5'(LEN - 1);

  state_t                  state, state_next;
  logic [4:0]              idx;
  logic [4:0]              off;
  logic [7:0]              chk;
  logic [7:0]              seq;
  logic [31:0]             timer;
  logic                    snap;
  logic                    trig;
  logic                    accept;
  logic [7:0]              frame_byte;
  logic [NUM_CH-1:0]       fresh;
  logic [NUM_CH-1:0][15:0] shadow;
  logic [7:0]              mask;

  framer_capture_bank #(
    .NUM_CH (NUM_CH),
    .DW     (DW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .value_i  (value_i),
    .valid_i  (valid_i),
    .snap     (snap),
    .fresh    (fresh),
    .shadow   (shadow),
    .mask     (mask),
    .drop_cnt (drop_cnt_o)
  );

  assign trig = (&fresh) ||
                ((TIMEOUT_CYCLES != 0) && (timer >= TIMEOUT_CYCLES) && (|fresh));
  assign accept = (state == SEND) && !byte_full_i;

  always_comb begin
    state_next = state;
    snap       = 1'b0;
    case (state)
      IDLE: if (trig) begin
        snap       = 1'b1;
        state_next = SEND;
      end
      SEND: if (accept && idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Channel bytes start at index 3: even offset is MSB, odd offset is LSB.
  always_comb begin
    frame_byte = 8'h00;
    off        = idx - 5'd3;
    if (idx == 5'd0)      frame_byte = SYNC_BYTE;
    else if (idx == 5'd1) frame_byte = seq;
    else if (idx == 5'd2) frame_byte = mask;
    else if (idx == LAST) frame_byte = chk;
    else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (off[4:1] == 4'(c)) frame_byte = off[0] ? shadow[c][7:0] : shadow[c][15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 5'd0;
      chk   <= 8'h00;
      seq   <= 8'h00;
      timer <= 32'd0;
    end else begin
      state <= state_next;
      if (snap) begin
        idx   <= 5'd0;
        chk   <= 8'h00;
        timer <= 32'd0;
      end else begin
        if (state == IDLE && timer < TIMEOUT_CYCLES) timer <= timer + 32'd1;
        if (accept) begin
          idx <= idx + 5'd1;
          if (idx != 5'd0 && idx != LAST) chk <= chk ^ frame_byte;
          if (idx == LAST) seq <= seq + 8'd1;
        end
      end
    end
  end

  assign byte_o    = (state == SEND) ? frame_byte : 8'h00;
  assign byte_wr_o = accept;
  assign busy_o    = (state == SEND);
  assign seq_o     = seq;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: instance a uses the default timeout, instance b a 100-cycle timeout.
module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] value_a, value_b;
  logic [3:0]  valid_a, valid_b;
  logic        full_a, full_b;
  logic [7:0]  byte_a, byte_b, seq_a, seq_b, drop_a, drop_b;
  logic        wr_a, wr_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base;
  int ref_cyc;
  int start_dly;
  logic [7:0] got_a[$], got_b[$];
  int         cyc_a[$], cyc_b[$];
  logic [7:0] expb[12];

  always #5 clk = ~clk;

  telemetry_framer dut_a (
    .clk(clk), .rst(rst), .value_i(value_a), .valid_i(valid_a),
    .byte_o(byte_a), .byte_wr_o(wr_a), .byte_full_i(full_a),
    .busy_o(busy_a), .seq_o(seq_a), .drop_cnt_o(drop_a)
  );

  telemetry_framer #(.TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst(rst), .value_i(value_b), .valid_i(valid_b),
    .byte_o(byte_b), .byte_wr_o(wr_b), .byte_full_i(full_b),
    .busy_o(busy_b), .seq_o(seq_b), .drop_cnt_o(drop_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_a === 1'b1) begin got_a.push_back(byte_a); cyc_a.push_back(cyc); end
    if (wr_b === 1'b1) begin got_b.push_back(byte_b); cyc_b.push_back(cyc); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_exp(input logic [7:0] s, input logic [7:0] m,
                          input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
    logic [7:0] x;
    expb[0]  = 8'hA5;    expb[1]  = s;         expb[2]  = m;
    expb[3]  = c0[15:8]; expb[4]  = c0[7:0];
    expb[5]  = c1[15:8]; expb[6]  = c1[7:0];
    expb[7]  = c2[15:8]; expb[8]  = c2[7:0];
    expb[9]  = c3[15:8]; expb[10] = c3[7:0];
    x = 8'h00;
    for (int i = 1; i < 11; i++) x = x ^ expb[i];
    expb[11] = x;
  endtask

  task automatic cmp_frame_a(input string tag, input int b);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] o;
      o = (b + i < got_a.size()) ? got_a[b+i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, o}, {24'h0, expb[i]});
    end
  endtask

  task automatic cmp_frame_b(input string tag, input int b);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] o;
      o = (b + i < got_b.size()) ? got_b[b+i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, o}, {24'h0, expb[i]});
    end
  endtask

  task automatic wait_a(input string tag, input int n, input int budget);
    int k = 0;
    while (got_a.size() < n && k < budget) begin tick(); k++; end
    check(tag, 32'(got_a.size() >= n), 32'd1);
  endtask

  task automatic wait_b(input string tag, input int n, input int budget);
    int k = 0;
    while (got_b.size() < n && k < budget) begin tick(); k++; end
    check(tag, 32'(got_b.size() >= n), 32'd1);
  endtask

  task automatic send_all_a(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
    value_a = {c3, c2, c1, c0};
    valid_a = 4'hF;
    tick();
    valid_a = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    value_a = '0; value_b = '0; valid_a = '0; valid_b = '0;
    full_a = 1'b0; full_b = 1'b0;
    repeat (3) tick();

    check("rst_wr",   {31'b0, wr_a},   32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_byte", {24'b0, byte_a}, 32'd0);
    check("rst_seq",  {24'b0, seq_a},  32'd0);
    check("rst_drop", {24'b0, drop_a}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: all four channels fresh in one cycle, no backpressure
    base = got_a.size();
    send_all_a(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    wait_a("t1_wait", base + 12, 40);
    expb = '{8'hA5, 8'h00, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h07};
    cmp_frame_a("t1", base);
    check("t1_consecutive", 32'((got_a.size() >= base + 12) ? cyc_a[base+11] - cyc_a[base] : -1), 32'd11);
    tick(); tick();
    check("t1_seq",  {24'b0, seq_a},  32'd1);
    check("t1_busy", {31'b0, busy_a}, 32'd0);

    // Test 2: FIFO full for 5 cycles while index is 3
    base = got_a.size();
    send_all_a(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    for (int k = 0; k < 40 && got_a.size() < base + 3; k++) tick();
    full_a = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t2_nowrite", {31'b0, wr_a},   32'd0);
      check("t2_hold",    {24'b0, byte_a}, 32'h01);
    end
    @(posedge clk);
    #1;
    full_a = 1'b0;
    check("t2_stall_count", 32'(got_a.size()), 32'(base + 3));
    wait_a("t2_wait", base + 12, 40);
    make_exp(8'h01, 8'h0F, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    cmp_frame_a("t2", base);

    // Test 4: ch2 overwritten before the trigger
    base = got_a.size();
    value_a[47:32] = 16'h1111; valid_a = 4'b0100; tick();
    value_a[47:32] = 16'h2222; tick();
    valid_a = 4'b0000; tick();
    check("t4_drop", {24'b0, drop_a}, 32'd1);
    check("t4_idle", {31'b0, busy_a}, 32'd0);
    value_a = {16'h0E0F, 16'h2222, 16'h0C0D, 16'h0A0B};
    valid_a = 4'b1011; tick(); valid_a = 4'b0000;
    wait_a("t4_wait", base + 12, 40);
    make_exp(8'h02, 8'h0F, 16'h0A0B, 16'h0C0D, 16'h2222, 16'h0E0F);
    cmp_frame_a("t4", base);

    // Test 5: ch0 update during SEND lands in the following frame
    base = got_a.size();
    send_all_a(16'h1001, 16'h2002, 16'h3003, 16'h4004);
    for (int k = 0; k < 40 && got_a.size() < base + 4; k++) tick();
    value_a[15:0] = 16'hBEEF; valid_a = 4'b0001; tick(); valid_a = 4'b0000;
    wait_a("t5_wait", base + 12, 40);
    make_exp(8'h03, 8'h0F, 16'h1001, 16'h2002, 16'h3003, 16'h4004);
    cmp_frame_a("t5", base);
    tick();
    check("t5_drop", {24'b0, drop_a}, 32'd1);
    base = got_a.size();
    value_a = {16'h7777, 16'h6666, 16'h5555, 16'h0000};
    valid_a = 4'b1110; tick(); valid_a = 4'b0000;
    wait_a("t5_next_wait", base + 12, 40);
    make_exp(8'h04, 8'h0F, 16'hBEEF, 16'h5555, 16'h6666, 16'h7777);
    cmp_frame_a("t5_next", base);

    // Test 6: reset while index is 5
    base = got_a.size();
    send_all_a(16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB);
    for (int k = 0; k < 40 && got_a.size() < base + 5; k++) tick();
    rst = 1'b1;
    tick();
    check("t6_wr",   {31'b0, wr_a},   32'd0);
    check("t6_busy", {31'b0, busy_a}, 32'd0);
    check("t6_seq",  {24'b0, seq_a},  32'd0);
    check("t6_drop", {24'b0, drop_a}, 32'd0);
    rst = 1'b0;
    tick();
    base = got_a.size();
    send_all_a(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_a("t6_wait", base + 12, 40);
    make_exp(8'h00, 8'h0F, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    cmp_frame_a("t6", base);

    // Test 3: timeout-forced partial frame on instance b
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    value_b = {16'h0000, 16'h0000, 16'h00FF, 16'h0000};
    valid_b = 4'b0010;
    ref_cyc = cyc;
    tick();
    valid_b = 4'b0000;
    repeat (90) tick();
    check("t3_early", 32'(got_b.size()), 32'd0);
    wait_b("t3_wait", 12, 60);
    start_dly = (got_b.size() > 0) ? cyc_b[0] - ref_cyc : 0;
    check("t3_start_window", 32'(start_dly >= 100 && start_dly <= 103), 32'd1);
    make_exp(8'h00, 8'h02, 16'h0000, 16'h00FF, 16'h0000, 16'h0000);
    cmp_frame_b("t3", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
